// File: rtl/router_fifo_pkt.sv
// Packet-aware router output FIFO with SOP/EOP qualifiers and error flags.
// Optional read-side parity check enabled by ROUTER_FIFO_PARITY_EN.
module router_fifo_pkt #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR       = 4,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  soft_reset,
  input  logic                  write_enb,
  input  logic                  lfd_state,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_enb,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  sop,
  output logic                  eop,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR:0]         count,
  output logic                  overflow_err,
  output logic                  frame_err,
  output logic                  parity_err
);

  localparam int RW = DATA_WIDTH - 1;
  localparam int LW = DATA_WIDTH - 2;

  typedef enum logic {S_IDLE, S_IN_PKT} state_t;

  logic [DATA_WIDTH:0]   r_mem [DEPTH];
  logic [ADDR:0]         r_wr_ptr;
  logic [ADDR:0]         r_rd_ptr;
  logic [ADDR:0]         r_count;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [RW-1:0]         r_rem;
  logic [RW-1:0]         w_rem_nxt;
  logic [RW-1:0]         w_reload;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_sop_nxt;
  logic                  w_eop_nxt;
  logic                  w_frame_set;
  logic [DATA_WIDTH:0]   w_rd_entry;
  logic [DATA_WIDTH-1:0] w_rd_byte;
  logic                  w_rd_hdr;
  logic [LW-1:0]         w_len;

  assign full        = (r_count == (ADDR+1)'(DEPTH));
  assign empty       = (r_count == '0);
  assign almost_full = (32'(r_count) >= 32'(DEPTH - AF_MARGIN));
  assign count       = r_count;

  // Flush dominates any same-cycle transfer.
  assign w_wr_acc = write_enb & ~full & ~soft_reset;
  assign w_rd_acc = read_enb & ~empty & ~soft_reset;

  assign w_rd_entry = r_mem[r_rd_ptr[ADDR-1:0]];
  assign w_rd_byte  = w_rd_entry[DATA_WIDTH-1:0];
  assign w_rd_hdr   = w_rd_entry[DATA_WIDTH];
  assign w_len      = w_rd_entry[DATA_WIDTH-1:2];
  // Payload length plus the trailing parity byte.
  assign w_reload   = {1'b0, w_len} + RW'(1);

  // Storage array; header flag kept in the MSB, never reset.
  always_ff @(posedge clock) begin
    if (w_wr_acc) r_mem[r_wr_ptr[ADDR-1:0]] <= {lfd_state, data_in};
  end

  // Pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (soft_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Read FSM state register and remaining-byte counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
    end else if (soft_reset) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  // Packet boundary tracking from header length fields.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_sop_nxt   = 1'b0;
    w_eop_nxt   = 1'b0;
    w_frame_set = 1'b0;
    if (w_rd_acc) begin
      case (r_state)
        S_IDLE: begin
          if (w_rd_hdr) begin
            w_sop_nxt   = 1'b1;
            w_rem_nxt   = w_reload;
            w_state_nxt = S_IN_PKT;
          end else begin
            w_frame_set = 1'b1;
          end
        end
        S_IN_PKT: begin
          if (w_rd_hdr) begin
            w_frame_set = 1'b1;
            w_sop_nxt   = 1'b1;
            w_rem_nxt   = w_reload;
          end else begin
            w_rem_nxt = r_rem - 1'b1;
            if (r_rem == RW'(1)) begin
              w_eop_nxt   = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Registered read data and qualifiers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      sop        <= 1'b0;
      eop        <= 1'b0;
    end else if (soft_reset) begin
      data_valid <= 1'b0;
      sop        <= 1'b0;
      eop        <= 1'b0;
    end else begin
      data_valid <= w_rd_acc;
      sop        <= w_sop_nxt;
      eop        <= w_eop_nxt;
      if (w_rd_acc) data_out <= w_rd_byte;
    end
  end

  // Sticky overflow and framing errors.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_err <= 1'b0;
      frame_err    <= 1'b0;
    end else if (soft_reset) begin
      overflow_err <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      if (write_enb && full) overflow_err <= 1'b1;
      if (w_frame_set) frame_err <= 1'b1;
    end
  end

`ifdef ROUTER_FIFO_PARITY_EN
  logic [DATA_WIDTH-1:0] r_par;
  logic                  r_parity_err;

  assign parity_err = r_parity_err;

  // Running XOR of header and payload; compared against the eop byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_par        <= '0;
      r_parity_err <= 1'b0;
    end else if (soft_reset) begin
      r_par        <= '0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      if (w_rd_acc) begin
        if (w_sop_nxt) begin
          r_par <= w_rd_byte;
        end else if (w_eop_nxt) begin
          r_parity_err <= (r_par != w_rd_byte);
          r_par        <= '0;
        end else begin
          r_par <= r_par ^ w_rd_byte;
        end
      end
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_fifo_pkt.sv
// Directed self-checking bench for router_fifo_pkt.
// Table vectors for packets, hand sequences for multi-cycle corners.
module tb_router_fifo_pkt;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       read_enb = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       sop;
  logic       eop;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [4:0] count;
  logic       overflow_err;
  logic       frame_err;
  logic       parity_err;

  int n_err = 0;
  int n_chk = 0;
  logic [7:0] exp_dout;

  router_fifo_pkt #(
    .DATA_WIDTH(8), .DEPTH(16),
    .ADDR(4), .AF_MARGIN(2)
  ) dut (
    .clock(clock), .reset(reset),
    .soft_reset(soft_reset),
    .write_enb(write_enb),
    .lfd_state(lfd_state),
    .data_in(data_in),
    .read_enb(read_enb),
    .data_out(data_out),
    .data_valid(data_valid),
    .sop(sop), .eop(eop),
    .full(full), .empty(empty),
    .almost_full(almost_full),
    .count(count),
    .overflow_err(overflow_err),
    .frame_err(frame_err),
    .parity_err(parity_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       we;
    logic       lfd;
    logic [7:0] din;
    logic       re;
    logic [7:0] dout;
    logic       dv;
    logic       sop;
    logic       eop;
    logic [4:0] cnt;
    logic       ferr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic we, input logic lfd,
    input logic [7:0] din, input logic re,
    input logic [7:0] dout, input logic dv,
    input logic s, input logic e,
    input logic [4:0] cnt, input logic fe);
    vec_t v;
    v.we = we; v.lfd = lfd; v.din = din;
    v.re = re; v.dout = dout; v.dv = dv;
    v.sop = s; v.eop = e; v.cnt = cnt;
    v.ferr = fe;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               nm, act, req);
    end
  endtask

  task automatic cyc(input logic s, input logic we,
                     input logic lfd,
                     input logic [7:0] d,
                     input logic re);
    soft_reset = s;
    write_enb  = we;
    lfd_state  = lfd;
    data_in    = d;
    read_enb   = re;
    @(posedge clock);
    #1;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    lfd_state  = 1'b0;
    read_enb   = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] e;
  logic       rd_ok;
  logic       wr_ok;
  int         c;

  initial begin
    // Packet: 0D (len 3), 11,22,33, parity 0D
    tbl.push_back(mk(1,1,8'h0D,0, 8'h00,0,0,0,5'd1,0));
    tbl.push_back(mk(1,0,8'h11,0, 8'h00,0,0,0,5'd2,0));
    tbl.push_back(mk(1,0,8'h22,0, 8'h00,0,0,0,5'd3,0));
    tbl.push_back(mk(1,0,8'h33,0, 8'h00,0,0,0,5'd4,0));
    tbl.push_back(mk(1,0,8'h0D,0, 8'h00,0,0,0,5'd5,0));
    tbl.push_back(mk(0,0,8'h00,1, 8'h0D,1,1,0,5'd4,0));
    tbl.push_back(mk(0,0,8'h00,1, 8'h11,1,0,0,5'd3,0));
    tbl.push_back(mk(0,0,8'h00,1, 8'h22,1,0,0,5'd2,0));
    tbl.push_back(mk(0,0,8'h00,1, 8'h33,1,0,0,5'd1,0));
    tbl.push_back(mk(0,0,8'h00,1, 8'h0D,1,0,1,5'd0,0));
    tbl.push_back(mk(0,0,8'h00,0, 8'h0D,0,0,0,5'd0,0));
    // Header len=0: next byte is eop
    tbl.push_back(mk(1,1,8'h01,0, 8'h0D,0,0,0,5'd1,0));
    tbl.push_back(mk(1,0,8'hAA,0, 8'h0D,0,0,0,5'd2,0));
    tbl.push_back(mk(0,0,8'h00,1, 8'h01,1,1,0,5'd1,0));
    tbl.push_back(mk(0,0,8'h00,1, 8'hAA,1,0,1,5'd0,0));
    // Read on empty is rejected
    tbl.push_back(mk(0,0,8'h00,1, 8'hAA,0,0,0,5'd0,0));

    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_cnt", 64'(count), 64'd0);
    chk("rst_flags",
        64'({empty, full, almost_full, data_valid,
             sop, eop, overflow_err, frame_err}),
        64'b1000_0000);
    chk("rst_dout", 64'(data_out), 64'h00);
    reset = 1'b0;

    foreach (tbl[i]) begin
      cyc(0, tbl[i].we, tbl[i].lfd,
          tbl[i].din, tbl[i].re);
      chk($sformatf("vec%0d", i),
          64'({data_out, data_valid, sop, eop,
               count, empty, frame_err,
               parity_err}),
          64'({tbl[i].dout, tbl[i].dv, tbl[i].sop,
               tbl[i].eop, tbl[i].cnt,
               (tbl[i].cnt == 5'd0), tbl[i].ferr,
               1'b0}));
    end
    exp_dout = 8'hAA;

`ifdef ROUTER_FIFO_PARITY_EN
    // Bad parity: 05 ^ 12 = 17, send 00
    cyc(0, 1, 1, 8'h05, 0);
    cyc(0, 1, 0, 8'h12, 0);
    cyc(0, 1, 0, 8'h00, 0);
    cyc(0, 0, 0, 8'h00, 1);
    cyc(0, 0, 0, 8'h00, 1);
    cyc(0, 0, 0, 8'h00, 1);
    chk("perr_eop", 64'({eop, parity_err}),
        64'b11);
    cyc(0, 0, 0, 8'h00, 0);
    chk("perr_pulse", 64'(parity_err), 64'd0);
    exp_dout = 8'h00;
`endif

    // Fill 17 bytes with no reads
    for (int i = 0; i < 17; i++) begin
      c = (i + 1 > 16) ? 16 : i + 1;
      cyc(0, 1, 0, 8'(8'h40 + i), 0);
      if (i < 16) q.push_back(8'(8'h40 + i));
      chk($sformatf("fill%0d", i),
          64'({count, almost_full, full,
               overflow_err}),
          64'({5'(c), (c >= 14), (c == 16),
               (i == 16)}));
    end

    // Read+write held high for 40 cycles
    for (int k = 0; k < 40; k++) begin
      rd_ok = (q.size() > 0);
      wr_ok = (q.size() < 16);
      e = 8'h00;
      if (rd_ok) e = q.pop_front();
      if (wr_ok) q.push_back(8'(8'h80 + k));
      cyc(0, 1, 0, 8'(8'h80 + k), 1);
      chk($sformatf("rw%0d", k),
          64'({data_out, data_valid, count}),
          64'({e, 1'b1, 5'(q.size())}));
      exp_dout = e;
    end

    // Drain remaining entries in order
    for (int k = 0; k < 16; k++) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        cyc(0, 0, 0, 8'h00, 1);
        chk($sformatf("drain%0d", k),
            64'({data_out, data_valid, count}),
            64'({e, 1'b1, 5'(q.size())}));
        exp_dout = e;
      end
    end
    chk("drain_empty", 64'(empty), 64'd1);
    chk("ferr_sticky", 64'({frame_err,
        overflow_err}), 64'b11);

    // Flush with read and write asserted
    cyc(0, 1, 0, 8'hC1, 0);
    cyc(0, 1, 0, 8'hC2, 0);
    cyc(1, 1, 1, 8'hFF, 1);
    chk("srst_state",
        64'({count, empty, data_valid, sop, eop,
             overflow_err, frame_err}),
        64'({5'd0, 1'b1, 5'b0}));
    chk("srst_dout", 64'(data_out),
        64'(exp_dout));

    // Non-header read first -> framing error
    cyc(0, 1, 0, 8'h77, 0);
    cyc(0, 0, 0, 8'h00, 1);
    chk("frame_nohdr",
        64'({data_out, data_valid, sop,
             frame_err}),
        64'({8'h77, 1'b1, 1'b0, 1'b1}));

    // Async reset between edges
    cyc(0, 1, 1, 8'h21, 0);
    cyc(0, 1, 0, 8'h22, 0);
    cyc(0, 0, 0, 8'h00, 1);
    #3 reset = 1'b1;
    #1;
    chk("arst_now",
        64'({count, empty, data_out, data_valid,
             sop, frame_err}),
        64'({5'd0, 1'b1, 8'h00, 3'b000}));
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    cyc(0, 1, 1, 8'h5A, 0);
    cyc(0, 0, 0, 8'h00, 1);
    chk("arst_first",
        64'({data_out, data_valid, sop, count}),
        64'({8'h5A, 1'b1, 1'b1, 5'd0}));

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
